// File: rtl/booth_mult_seq_if.sv
// Operand/result handshake bundle for the sequential Booth multiplier.
// The master drives operands and consumes the product; the slave is the multiplier.
interface booth_mult_seq_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               is_signed;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one add/sub-and-shift step per clock on
// (WIDTH+1)-bit extended operands, result held until the consumer accepts it.
module booth_mult_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+2)
) (
  input logic             clk,
  input logic             rst_n,
  booth_mult_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_n;
  logic [WIDTH:0]     acc, q, m;
  logic               q_m1;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod_q;

  logic [WIDTH:0]     sum, acc_sh, q_sh;
  logic               last;

  // Booth recoding of {Q[0], q_-1}; WIDTH+1 bit wrap-around is exact here
  always_comb begin
    sum = acc;
    case ({q[0], q_m1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
  end

  assign acc_sh = {sum[WIDTH], sum[WIDTH:1]};
  assign q_sh   = {sum[0], q[WIDTH:1]};
  assign last   = (cnt == CNT_W'(WIDTH));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_n = CALC;
      CALC:    if (last)          state_n = DONE;
      DONE:    if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      q      <= '0;
      q_m1   <= 1'b0;
      m      <= '0;
      cnt    <= '0;
      prod_q <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (bus.in_valid) begin
          acc  <= '0;
          q    <= {bus.is_signed & bus.b[WIDTH-1], bus.b};
          m    <= {bus.is_signed & bus.a[WIDTH-1], bus.a};
          q_m1 <= 1'b0;
          cnt  <= '0;
        end
        CALC: begin
          acc  <= acc_sh;
          q    <= q_sh;
          q_m1 <= q[0];
          cnt  <= cnt + 1'b1;
          // {acc,q} is 2*WIDTH+2 bits; the top two are pure sign extension
          if (last) prod_q <= {acc_sh[WIDTH-2:0], q_sh};
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.product   = prod_q;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed WIDTH=8 vectors plus random sweeps at WIDTH 8/12/16 against a
// sign/zero-extended multiply reference.
module tb_booth_mult_seq;
  localparam int NOPS = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   sweep_go = 1'b0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- directed DUT (WIDTH=8) ----------------
  booth_mult_seq_if #(.WIDTH(8)) bus8 ();
  booth_mult_seq #(.WIDTH(8)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus8));

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic s);
    @(negedge clk);
    bus8.a = a; bus8.b = b; bus8.is_signed = s; bus8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    bus8.a = ~a; bus8.b = ~b; bus8.is_signed = ~s;
  endtask

  task automatic wait_out8(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!bus8.out_valid && cyc < 40);
  endtask

  task automatic take8;
    bus8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus8.out_ready = 1'b0;
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic s, input logic [15:0] exp);
    int cyc;
    start8(a, b, s);
    wait_out8(cyc);
    check({tag, "_lat"}, 64'(cyc), 64'd9);
    check({tag, "_prod"}, 64'(bus8.product), 64'(exp));
    take8();
    check({tag, "_rdy"}, 64'(bus8.in_ready), 64'd1);
  endtask

  initial begin
    int  cyc;
    bit  saw;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
    bus8.a = '0; bus8.b = '0; bus8.is_signed = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(bus8.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus8.out_valid), 64'd0);
    check("rst_busy", 64'(bus8.busy), 64'd0);
    check("rst_product", 64'(bus8.product), 64'd0);
    rst_n = 1'b1;

    // -3 * 5, with CALC status checked right after the accept edge
    start8(8'hFD, 8'h05, 1'b1);
    check("calc_busy", 64'(bus8.busy), 64'd1);
    check("calc_in_ready", 64'(bus8.in_ready), 64'd0);
    wait_out8(cyc);
    check("neg3x5_lat", 64'(cyc), 64'd9);
    check("neg3x5_prod", 64'(bus8.product), 64'hFFF1);
    check("done_busy", 64'(bus8.busy), 64'd1);
    take8();
    check("neg3x5_ovld", 64'(bus8.out_valid), 64'd0);
    check("neg3x5_hold", 64'(bus8.product), 64'hFFF1);

    op8("ffxff_u", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    op8("ffxff_s", 8'hFF, 8'hFF, 1'b1, 16'h0001);
    op8("80x80_s", 8'h80, 8'h80, 1'b1, 16'h4000);
    op8("80x7f_s", 8'h80, 8'h7F, 1'b1, 16'hC080);
    op8("80x00_s", 8'h80, 8'h00, 1'b1, 16'h0000);
    op8("80x80_u", 8'h80, 8'h80, 1'b0, 16'h4000);

    // backpressure with an ignored in_valid pulse
    start8(8'h03, 8'h04, 1'b0);
    wait_out8(cyc);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus8.a = 8'h11; bus8.b = 8'h11; bus8.in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      bus8.in_valid = 1'b0;
      check("bp_ovld", 64'(bus8.out_valid), 64'd1);
      check("bp_prod", 64'(bus8.product), 64'h000C);
      check("bp_in_ready", 64'(bus8.in_ready), 64'd0);
    end
    take8();
    check("bp_release_rdy", 64'(bus8.in_ready), 64'd1);
    check("bp_release_ovld", 64'(bus8.out_valid), 64'd0);
    saw = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus8.out_valid || bus8.busy) saw = 1'b1;
    end
    check("bp_no_queue", 64'(saw), 64'd0);
    op8("2x3_u", 8'h02, 8'h03, 1'b0, 16'h0006);

    // async reset at step 4 of a CALC
    start8(8'h55, 8'h33, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_in_ready", 64'(bus8.in_ready), 64'd1);
    check("mrst_out_valid", 64'(bus8.out_valid), 64'd0);
    check("mrst_busy", 64'(bus8.busy), 64'd0);
    check("mrst_product", 64'(bus8.product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (bus8.out_valid) saw = 1'b1;
    end
    check("mrst_no_ovld", 64'(saw), 64'd0);
    check("mrst_rdy_after", 64'(bus8.in_ready), 64'd1);
    op8("7x6_u", 8'h07, 8'h06, 1'b0, 16'h002A);

    // random sweeps at all three widths in parallel
    sweep_go = 1'b1;
    for (int i = 0; i < 60000 && !(sw[0].done && sw[1].done && sw[2].done); i++)
      @(posedge clk);
    check("sweep_done", 64'({sw[0].done, sw[1].done, sw[2].done}), 64'b111);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  // ---------------- random sweep DUTs ----------------
  for (genvar g = 0; g < 3; g++) begin : sw
    localparam int W = (g == 0) ? 8 : (g == 1) ? 12 : 16;
    bit done = 1'b0;

    booth_mult_seq_if #(.WIDTH(W)) sbus ();
    booth_mult_seq #(.WIDTH(W)) u_sw (.clk(clk), .rst_n(rst_n), .bus(sbus));

    initial begin
      logic [W-1:0] ra, rb;
      logic         rs;
      logic [63:0]  ea, eb, ex;
      int           hs;
      bit           got;
      string        tag;
      tag = $sformatf("sweep_w%0d", W);
      hs = 0;
      sbus.in_valid = 1'b0; sbus.out_ready = 1'b0;
      sbus.a = '0; sbus.b = '0; sbus.is_signed = 1'b0;
      wait (sweep_go);
      for (int n = 0; n < NOPS; n++) begin
        ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
        if (n % 16 == 0) ra = {1'b1, {(W-1){1'b0}}};
        if (n % 32 == 0) rb = {1'b1, {(W-1){1'b0}}};
        ea = rs ? 64'($signed(ra)) : 64'(ra);
        eb = rs ? 64'($signed(rb)) : 64'(rb);
        ex = (ea * eb) & ((64'd1 << (2*W)) - 64'd1);
        @(negedge clk);
        sbus.a = ra; sbus.b = rb; sbus.is_signed = rs; sbus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        sbus.in_valid = 1'b0;
        sbus.a = W'($urandom); sbus.b = W'($urandom); sbus.is_signed = 1'($urandom);
        got = 1'b0;
        for (int t = 0; t < 200 && !got; t++) begin
          @(negedge clk);
          if (sbus.out_valid) begin
            sbus.out_ready = ($urandom_range(0, 2) != 0);
            if (sbus.out_ready) begin
              check(tag, 64'(sbus.product), ex);
              got = 1'b1;
              hs++;
            end
          end else begin
            sbus.out_ready = 1'($urandom);
          end
        end
        if (!got) check({tag, "_timeout"}, 64'd0, 64'd1);
        @(posedge clk);
        #1;
        sbus.out_ready = 1'b0;
      end
      check({tag, "_handshakes"}, 64'(hs), 64'(NOPS));
      done = 1'b1;
    end
  end
endmodule
